// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipe_stage_skid (optional PIPE_STAGE_PERF_EN)
package pipe_pkg;

   // Encoding doubles as the occupancy count driven on occ_o
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_occ_e;

   localparam int unsigned PIPE_PC_W   = 32;
   localparam int unsigned PIPE_DATA_W = 32;
   localparam int unsigned PIPE_CNT_W  = 16;

   // Bubble payload: an all-zero word is the NOP encoding
   localparam int unsigned PIPE_NOP    = 0;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter with synchronous active-low clear
module pipe_sat_counter
   import pipe_pkg::*;
#(
   parameter int unsigned W = PIPE_CNT_W
) (
   input  logic         clk_i,
   input  logic         clr_n_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Increment on request, holding at all-ones once reached
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register, cleared synchronously
   always_ff @(posedge clk_i) begin
      if (!clr_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with two-entry skid buffer (optional PIPE_STAGE_PERF_EN)
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned PC_W   = PIPE_PC_W,
   parameter int unsigned DATA_W = PIPE_DATA_W
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int unsigned CNT_W  = PIPE_CNT_W
`endif
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [PC_W-1:0]   pc_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        occ_o
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

   pipe_occ_e         state_q, state_d;
   logic [PC_W-1:0]   main_pc_q, main_pc_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              in_fire, out_fire;

   assign in_fire  = in_valid_i & in_ready_q;
   assign out_fire = out_valid_q & out_ready_i;

   // Occupancy transitions; flush wins and bubbles every held entry
   always_comb begin
      state_d     = state_q;
      main_pc_d   = main_pc_q;
      main_data_d = main_data_q;
      skid_pc_d   = skid_pc_q;
      skid_data_d = skid_data_q;
      if (flush_i) begin
         state_d     = ST_EMPTY;
         main_pc_d   = '0;
         main_data_d = DATA_W'(PIPE_NOP);
         skid_pc_d   = '0;
         skid_data_d = DATA_W'(PIPE_NOP);
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d     = ST_ONE;
                  main_pc_d   = pc_i;
                  main_data_d = data_i;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_pc_d   = pc_i;
                  main_data_d = data_i;
               end else if (in_fire) begin
                  state_d     = ST_TWO;
                  skid_pc_d   = pc_i;
                  skid_data_d = data_i;
               end else if (out_fire) begin
                  state_d     = ST_EMPTY;
                  main_pc_d   = '0;
                  main_data_d = DATA_W'(PIPE_NOP);
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_d     = ST_ONE;
                  main_pc_d   = skid_pc_q;
                  main_data_d = skid_data_q;
                  skid_pc_d   = '0;
                  skid_data_d = DATA_W'(PIPE_NOP);
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      // Registered handshake flags follow the next state so no output is combinational
      in_ready_d  = (state_d != ST_TWO);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // Storage and handshake registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_EMPTY;
         main_pc_q   <= '0;
         main_data_q <= DATA_W'(PIPE_NOP);
         skid_pc_q   <= '0;
         skid_data_q <= DATA_W'(PIPE_NOP);
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_pc_q   <= main_pc_d;
         main_data_q <= main_data_d;
         skid_pc_q   <= skid_pc_d;
         skid_data_q <= skid_data_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign pc_o        = main_pc_q;
   assign data_o      = main_data_q;
   assign occ_o       = state_q;

`ifdef PIPE_STAGE_PERF_EN
   pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .clr_n_i (rst_n_i),
      .inc_i   (out_valid_q & ~out_ready_i),
      .cnt_o   (stall_cnt_o)
   );

   pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .clr_n_i (rst_n_i),
      .inc_i   (flush_i & (state_q != ST_EMPTY)),
      .cnt_o   (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid (covers PIPE_STAGE_PERF_EN when defined)
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_in;
   logic [31:0] data_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_out;
   logic [31:0] data_out;
   logic [1:0]  occ;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_in_ready, s_out_valid;
   logic [31:0] s_pc_out, s_data_out;
   logic [1:0]  s_occ, s_stall_cnt, s_flush_cnt;

   pipe_stage_skid dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .pc_i(pc_in), .data_i(data_in),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_out), .data_o(data_out),
      .occ_o(occ), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   pipe_stage_skid #(.CNT_W(2)) dut_small (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(s_in_ready), .pc_i(pc_in), .data_i(data_in),
      .out_valid_o(s_out_valid), .out_ready_i(out_ready), .pc_o(s_pc_out), .data_o(s_data_out),
      .occ_o(s_occ), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
   );
`else
   pipe_stage_skid dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .pc_i(pc_in), .data_i(data_in),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_out), .data_o(data_out),
      .occ_o(occ)
   );
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc);
      in_valid = 1'b1;
      pc_in    = pc;
      data_in  = 32'h8C01_0000 | pc;
   endtask

   task automatic expect_main(input string tag, input logic [31:0] pc, input logic [1:0] n);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_pc"},    pc_out,   pc);
      check({tag, "_data"},  data_out, 32'h8C01_0000 | pc);
      check({tag, "_occ"},   {30'd0, occ}, {30'd0, n});
   endtask

   task automatic expect_empty(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready"}, {31'd0, in_ready},  32'd1);
      check({tag, "_occ"},   {30'd0, occ},       32'd0);
      check({tag, "_pc"},    pc_out,   32'd0);
      check({tag, "_data"},  data_out, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      pc_in = '0; data_in = '0;
      #1;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      expect_empty("reset_idle");
`ifdef PIPE_STAGE_PERF_EN
      check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
`endif

      // Streaming with downstream always ready
      send(32'h00); tick(); expect_main("stream0", 32'h00, 2'd1);
      send(32'h04); tick(); expect_main("stream1", 32'h04, 2'd1);
      check("stream1_ready", {31'd0, in_ready}, 32'd1);
      send(32'h08); tick(); expect_main("stream2", 32'h08, 2'd1);
      in_valid = 1'b0; tick(); expect_empty("stream_drain");

      // Back-pressure fills the skid
      out_ready = 1'b0;
      send(32'h10); tick(); expect_main("stall0", 32'h10, 2'd1);
      check("stall0_ready", {31'd0, in_ready}, 32'd1);
      send(32'h14); tick(); expect_main("stall1", 32'h10, 2'd2);
      check("stall1_ready", {31'd0, in_ready}, 32'd0);
      send(32'h18); tick(); expect_main("stall_hold", 32'h10, 2'd2);
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); expect_main("release0", 32'h14, 2'd1);
      check("release0_ready", {31'd0, in_ready}, 32'd1);
      tick(); expect_empty("release_drain");

      // Flush while full with a concurrent input
      out_ready = 1'b0;
      send(32'h20); tick();
      send(32'h24); tick(); expect_main("pre_flush", 32'h20, 2'd2);
      flush = 1'b1; send(32'h28); tick(); expect_empty("flush");
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick(); expect_empty("flush_no_ghost");

      // Reset while full, then resume
      out_ready = 1'b0;
      send(32'h30); tick();
      send(32'h34); tick(); expect_main("pre_reset", 32'h30, 2'd2);
      rst_n = 1'b0; send(32'h38); tick(); expect_empty("mid_reset");
      rst_n = 1'b1; out_ready = 1'b1;
      send(32'h40); tick(); expect_main("resume", 32'h40, 2'd1);
      in_valid = 1'b0; tick(); expect_empty("resume_drain");

`ifdef PIPE_STAGE_PERF_EN
      // Counters: reset cleared them; earlier stalls since reset are none
      check("cnt_after_reset_stall", {16'd0, stall_cnt}, 32'd0);
      out_ready = 1'b0;
      send(32'h50); tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
      check("small_stall_sat", {30'd0, s_stall_cnt}, 32'd3);
      flush = 1'b1; out_ready = 1'b1; tick();
      flush = 1'b0;
      check("flush_cnt_1", {16'd0, flush_cnt}, 32'd1);
      check("stall_cnt_after_flush", {16'd0, stall_cnt}, 32'd5);
      check("small_flush_cnt", {30'd0, s_flush_cnt}, 32'd1);
      flush = 1'b1; tick(); flush = 1'b0;
      check("flush_empty_not_counted", {16'd0, flush_cnt}, 32'd1);
      out_ready = 1'b0;
      send(32'h60); tick(); in_valid = 1'b0; tick();
      check("small_stall_hold_sat", {30'd0, s_stall_cnt}, 32'd3);
      check("stall_cnt_6", {16'd0, stall_cnt}, 32'd6);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
